// File: rtl/johnson_phase_tracker.sv
// Tracks a free-running Johnson counter: decodes each sampled code to a phase,
// checks every step against the legal sequence, counts revolutions and reports lock/health.
module johnson_phase_tracker #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PH_W     = 3,
   parameter int unsigned REV_W    = 8,
   parameter int unsigned LOCK_LEN = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     q,
   input  logic                 clr,
   output logic [PH_W-1:0]      phase,
   output logic [2*WIDTH-1:0]   phase_oh,
   output logic                 valid,
   output logic                 illegal_code,
   output logic                 seq_err,
   output logic                 locked,
   output logic [REV_W-1:0]     rev_count,
   output logic                 err_sticky
);

   localparam int unsigned N   = 2 * WIDTH;
   localparam int unsigned LCW = $clog2(LOCK_LEN + 1);

   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;

   // Legal code for phase p: low p bits set up to all-ones, then ones drain from the bottom.
   function automatic logic [WIDTH-1:0] f_code(input int unsigned p);
      logic [WIDTH-1:0] c;
      if (p <= WIDTH) c = ~({WIDTH{1'b1}} << p);
      else            c = {WIDTH{1'b1}} << (p - WIDTH);
      return c;
   endfunction

   logic [WIDTH-1:0] r_q_s;
   logic [WIDTH-1:0] r_q_p;
   logic [0:0]       r_state;
   logic [LCW-1:0]   r_lock_cnt;
   logic [PH_W-1:0]  r_phase;
   logic [N-1:0]     r_phase_oh;
   logic             r_valid;
   logic             r_illegal;
   logic             r_seq_err;
   logic             r_locked;
   logic [REV_W-1:0] r_rev;
   logic             r_sticky;

   logic             w_legal_s;
   logic             w_legal_p;
   logic [PH_W-1:0]  w_ph_s;
   logic [PH_W-1:0]  w_ph_p;
   logic [WIDTH-1:0] w_succ_p;
   logic             w_hold;
   logic             w_adv;
   logic             w_illegal;
   logic             w_seq_err;
   logic             w_err;
   logic             w_wrap;
   logic [N-1:0]     w_oh_s;
   logic [0:0]       w_state_nxt;
   logic [LCW-1:0]   w_lock_cnt_nxt;
   logic [LCW-1:0]   w_lock_inc;

   // Decode both pipeline stages against the legal code table.
   always_comb begin
      w_legal_s = 1'b0;
      w_legal_p = 1'b0;
      w_ph_s    = '0;
      w_ph_p    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (r_q_s == f_code(i)) begin
            w_legal_s = 1'b1;
            w_ph_s    = PH_W'(i);
         end
         if (r_q_p == f_code(i)) begin
            w_legal_p = 1'b1;
            w_ph_p    = PH_W'(i);
         end
      end
   end

   assign w_succ_p  = {r_q_p[WIDTH-2:0], ~r_q_p[WIDTH-1]};
   assign w_hold    = w_legal_s && (r_q_s == r_q_p);
   // An illegal previous sample means resync: neither an advance nor a sequence error.
   assign w_adv     = w_legal_s && w_legal_p && (r_q_s == w_succ_p);
   assign w_seq_err = w_legal_s && w_legal_p && !w_hold && !w_adv;
   assign w_illegal = !w_legal_s;
   assign w_err     = w_illegal || w_seq_err;
   assign w_wrap    = w_adv && (w_ph_p == PH_W'(N - 1));
   assign w_oh_s    = w_legal_s ? (N'(1) << w_ph_s) : '0;
   assign w_lock_inc = r_lock_cnt + LCW'(1);

   // Lock FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_UNLOCKED;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
      end
   end

   // Lock FSM next state: consecutive advances lock, any error drops back to zero.
   always_comb begin
      w_state_nxt    = r_state;
      w_lock_cnt_nxt = r_lock_cnt;
      if (w_err) begin
         w_state_nxt    = ST_UNLOCKED;
         w_lock_cnt_nxt = '0;
      end else begin
         case (r_state)
            ST_UNLOCKED: begin
               if (w_adv) begin
                  w_lock_cnt_nxt = w_lock_inc;
                  if (w_lock_inc == LCW'(LOCK_LEN)) w_state_nxt = ST_LOCKED;
               end
            end
            default: ;
         endcase
      end
   end

   // Sampling pipeline and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q_s      <= '0;
         r_q_p      <= '0;
         r_phase    <= '0;
         r_phase_oh <= '0;
         r_valid    <= 1'b0;
         r_illegal  <= 1'b0;
         r_seq_err  <= 1'b0;
         r_locked   <= 1'b0;
         r_rev      <= '0;
         r_sticky   <= 1'b0;
      end else begin
         r_q_s      <= q;
         r_q_p      <= r_q_s;
         if (w_legal_s) r_phase <= w_ph_s;
         r_phase_oh <= w_oh_s;
         r_valid    <= w_legal_s;
         r_illegal  <= w_illegal;
         r_seq_err  <= w_seq_err;
         r_locked   <= (w_state_nxt == ST_LOCKED);
         if (clr)         r_rev <= '0;
         else if (w_wrap) r_rev <= r_rev + REV_W'(1);
         // A fresh error outranks a clear on the same edge.
         if (w_err)       r_sticky <= 1'b1;
         else if (clr)    r_sticky <= 1'b0;
      end
   end

   assign phase        = r_phase;
   assign phase_oh     = r_phase_oh;
   assign valid        = r_valid;
   assign illegal_code = r_illegal;
   assign seq_err      = r_seq_err;
   assign locked       = r_locked;
   assign rev_count    = r_rev;
   assign err_sticky   = r_sticky;

endmodule
